// File: rtl/ldpc_iter_sched_if.sv
// Scheduler-side bundle of the LDPC iteration scheduler: frame handshake,
// processing-unit start/end flags, syndrome status and the result handshake.
interface ldpc_iter_sched_if #(
    parameter int unsigned ITER_W = 5,
    parameter int unsigned N_BITS = 533
);
    logic              frame_valid;
    logic              frame_ready;
    logic              dec_abort;
    logic              flag_init_start;
    logic              flag_init_end;
    logic              flag_CFU_start;
    logic              flag_CFU_end;
    logic              flag_VFU_start;
    logic              flag_VFU_end;
    logic              flag_SCU_start;
    logic              flag_SCU_end;
    logic              syndrome_ok;
    logic [N_BITS-1:0] bit_data_in;
    logic              dec_valid;
    logic              dec_ready;
    logic [N_BITS-1:0] dec_bits;
    logic [ITER_W-1:0] dec_iter;
    logic              dec_ok;
    logic              dec_timeout;

    // The scheduler itself
    modport master (
        input  frame_valid, dec_abort,
        input  flag_init_end, flag_CFU_end, flag_VFU_end, flag_SCU_end,
        input  syndrome_ok, bit_data_in, dec_ready,
        output frame_ready,
        output flag_init_start, flag_CFU_start, flag_VFU_start, flag_SCU_start,
        output dec_valid, dec_bits, dec_iter, dec_ok, dec_timeout
    );

    // Processing units, frame source and result consumer
    modport slave (
        output frame_valid, dec_abort,
        output flag_init_end, flag_CFU_end, flag_VFU_end, flag_SCU_end,
        output syndrome_ok, bit_data_in, dec_ready,
        input  frame_ready,
        input  flag_init_start, flag_CFU_start, flag_VFU_start, flag_SCU_start,
        input  dec_valid, dec_bits, dec_iter, dec_ok, dec_timeout
    );
endinterface

// File: rtl/ldpc_iter_sched.sv
// LDPC iteration scheduler: LLR load, then CFU -> VFU -> SCU repeated until the
// syndrome passes or the iteration limit is hit, with a per-phase watchdog.
module ldpc_iter_sched #(
    parameter int unsigned MAX_ITER = 10,
    parameter int unsigned ITER_W   = 5,
    parameter int unsigned N_BITS   = 533,
    parameter int unsigned TIMEOUT  = 4096,
    parameter int unsigned TO_W     = 13
) (
    input logic               sys_clk,
    input logic               sys_rst_n,
    ldpc_iter_sched_if.master bus
);

    typedef enum logic [2:0] {StIdle, StInit, StCfu, StVfu, StScu, StDone} state_e;

    localparam logic [ITER_W-1:0] IterMax = ITER_W'(MAX_ITER);
    localparam logic [TO_W-1:0]   WdLast  = TO_W'(TIMEOUT - 1);

    state_e            state_q;
    logic              frame_ready_q;
    logic              init_start_q;
    logic              cfu_start_q;
    logic              vfu_start_q;
    logic              scu_start_q;
    logic              dec_valid_q;
    logic              dec_ok_q;
    logic              dec_timeout_q;
    logic [N_BITS-1:0] dec_bits_q;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] iter_inc;
    logic [TO_W-1:0]   wd_q;
    logic              unit_end;
    logic              wd_expired;

    // Only the end flag of the unit owned by the current phase counts
    always_comb begin
        unit_end = 1'b0;
        case (state_q)
            StInit:  unit_end = bus.flag_init_end;
            StCfu:   unit_end = bus.flag_CFU_end;
            StVfu:   unit_end = bus.flag_VFU_end;
            StScu:   unit_end = bus.flag_SCU_end;
            default: unit_end = 1'b0;
        endcase
    end

    assign wd_expired = (wd_q == WdLast);
    assign iter_inc   = iter_q + ITER_W'(1);

    // Phase sequencing, watchdog, start pulses and result registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            frame_ready_q <= 1'b1;
            init_start_q  <= 1'b0;
            cfu_start_q   <= 1'b0;
            vfu_start_q   <= 1'b0;
            scu_start_q   <= 1'b0;
            dec_valid_q   <= 1'b0;
            dec_ok_q      <= 1'b0;
            dec_timeout_q <= 1'b0;
            dec_bits_q    <= '0;
            iter_q        <= '0;
            wd_q          <= '0;
        end else begin
            // Start pulses last only for the first cycle of a phase
            init_start_q <= 1'b0;
            cfu_start_q  <= 1'b0;
            vfu_start_q  <= 1'b0;
            scu_start_q  <= 1'b0;
            if (state_q != StIdle && bus.dec_abort) begin
                // Abort outranks end flags and the result handshake
                state_q       <= StIdle;
                frame_ready_q <= 1'b1;
                dec_valid_q   <= 1'b0;
                wd_q          <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (bus.frame_valid) begin
                            state_q       <= StInit;
                            frame_ready_q <= 1'b0;
                            init_start_q  <= 1'b1;
                            iter_q        <= '0;
                            dec_ok_q      <= 1'b0;
                            dec_timeout_q <= 1'b0;
                            wd_q          <= '0;
                        end
                    end
                    StInit, StCfu, StVfu, StScu: begin
                        if (unit_end) begin
                            // An end flag on the watchdog's last cycle still wins
                            wd_q <= '0;
                            case (state_q)
                                StInit: begin
                                    state_q     <= StCfu;
                                    cfu_start_q <= 1'b1;
                                end
                                StCfu: begin
                                    state_q     <= StVfu;
                                    vfu_start_q <= 1'b1;
                                end
                                StVfu: begin
                                    state_q     <= StScu;
                                    scu_start_q <= 1'b1;
                                end
                                default: begin
                                    dec_bits_q <= bus.bit_data_in;
                                    iter_q     <= iter_inc;
                                    if (bus.syndrome_ok) begin
                                        state_q     <= StDone;
                                        dec_valid_q <= 1'b1;
                                        dec_ok_q    <= 1'b1;
                                    end else if (iter_inc == IterMax) begin
                                        state_q     <= StDone;
                                        dec_valid_q <= 1'b1;
                                        dec_ok_q    <= 1'b0;
                                    end else begin
                                        state_q     <= StCfu;
                                        cfu_start_q <= 1'b1;
                                    end
                                end
                            endcase
                        end else if (wd_expired) begin
                            state_q       <= StDone;
                            dec_valid_q   <= 1'b1;
                            dec_timeout_q <= 1'b1;
                            dec_ok_q      <= 1'b0;
                            wd_q          <= '0;
                        end else begin
                            wd_q <= wd_q + TO_W'(1);
                        end
                    end
                    StDone: begin
                        if (bus.dec_ready) begin
                            state_q       <= StIdle;
                            dec_valid_q   <= 1'b0;
                            frame_ready_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.frame_ready     = frame_ready_q;
    assign bus.flag_init_start = init_start_q;
    assign bus.flag_CFU_start  = cfu_start_q;
    assign bus.flag_VFU_start  = vfu_start_q;
    assign bus.flag_SCU_start  = scu_start_q;
    assign bus.dec_valid       = dec_valid_q;
    assign bus.dec_bits        = dec_bits_q;
    assign bus.dec_iter        = (iter_q > IterMax) ? IterMax : iter_q;
    assign bus.dec_ok          = dec_ok_q;
    assign bus.dec_timeout     = dec_timeout_q;

endmodule

// File: tb/tb_ldpc_iter_sched.sv
// Self-checking bench for ldpc_iter_sched: directed frame table, hand-written
// abort/reset/backpressure sequences and randomized frames against a phase-walk model.
module tb_ldpc_iter_sched;

    localparam int unsigned MAX_ITER = 3;
    localparam int unsigned ITER_W   = 5;
    localparam int unsigned N_BITS   = 533;
    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned TO_W     = 5;
    localparam int          NPH      = 1 + 3 * MAX_ITER;
    localparam int          HANG     = 1000;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    ldpc_iter_sched_if #(.ITER_W(ITER_W), .N_BITS(N_BITS)) bus ();

    ldpc_iter_sched #(
        .MAX_ITER(MAX_ITER),
        .ITER_W  (ITER_W),
        .N_BITS  (N_BITS),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Current frame plan: per-phase latency (start -> end), per-iteration syndrome and word
    int                lat  [NPH];
    bit                synd [MAX_ITER];
    logic [N_BITS-1:0] word [MAX_ITER];
    logic [N_BITS-1:0] last_bits = '0;

    typedef struct {
        int l;
        int pass_it;
        int hang_ph;
        int e_cyc;
        int e_cfu;
        int e_vfu;
        int e_scu;
        int e_iter;
        bit e_ok;
        bit e_to;
        int widx;
        int hold;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [N_BITS-1:0] act,
                         input logic [N_BITS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N_BITS-1:0] rand_word();
        logic [N_BITS-1:0] w = '0;
        for (int i = 0; i < (N_BITS + 31) / 32; i++) w = (w << 32) | N_BITS'($urandom);
        return w;
    endfunction

    task automatic drive_ends(input logic [3:0] e);
        bus.flag_init_end = e[0];
        bus.flag_CFU_end  = e[1];
        bus.flag_VFU_end  = e[2];
        bus.flag_SCU_end  = e[3];
    endtask

    task automatic clear_inputs();
        bus.frame_valid = 1'b0;
        bus.dec_abort   = 1'b0;
        bus.dec_ready   = 1'b0;
        bus.syndrome_ok = 1'b0;
        bus.bit_data_in = '0;
        drive_ends(4'b0000);
    endtask

    function automatic logic any_start();
        return bus.flag_init_start | bus.flag_CFU_start | bus.flag_VFU_start | bus.flag_SCU_start;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, ":ctrl"}, {bus.frame_ready, bus.flag_init_start, bus.flag_CFU_start,
                               bus.flag_VFU_start, bus.flag_SCU_start, bus.dec_valid,
                               bus.dec_ok, bus.dec_timeout}, 8'b1000_0000);
        check({tag, ":bits"}, bus.dec_bits, '0);
        check({tag, ":iter"}, bus.dec_iter, 0);
    endtask

    task automatic set_plan(input int l, input int pass_it, input int hang_ph,
                            input logic [N_BITS-1:0] base);
        for (int p = 0; p < NPH; p++) lat[p] = (p == hang_ph) ? HANG : l;
        for (int i = 0; i < MAX_ITER; i++) begin
            synd[i] = (i == pass_it);
            word[i] = base + N_BITS'(i);
        end
    endtask

    // Walk the phase list: a phase either ends (L+1 cycles to the next start) or
    // hangs past the watchdog (TIMEOUT cycles to the result).
    task automatic model(output int e_cyc, output int e_cfu, output int e_vfu, output int e_scu,
                         output int e_iter, output bit e_ok, output bit e_to,
                         output logic [N_BITS-1:0] e_bits);
        int  cnt [4];
        bit  done;
        int  u;
        int  it;
        cnt    = '{0, 0, 0, 0};
        done   = 1'b0;
        e_cyc  = 1;
        e_iter = 0;
        e_ok   = 1'b0;
        e_to   = 1'b0;
        e_bits = last_bits;
        for (int p = 0; p < NPH && !done; p++) begin
            u  = (p == 0) ? 0 : (p - 1) % 3 + 1;
            it = (p == 0) ? 0 : (p - 1) / 3;
            cnt[u]++;
            if (lat[p] > int'(TIMEOUT) - 1) begin
                e_cyc += TIMEOUT;
                e_to  = 1'b1;
                done  = 1'b1;
            end else begin
                e_cyc += lat[p] + 1;
                if (u == 3) begin
                    e_bits = word[it];
                    e_iter = it + 1;
                    if (synd[it]) begin
                        e_ok = 1'b1;
                        done = 1'b1;
                    end
                end
            end
        end
        e_cfu = cnt[1];
        e_vfu = cnt[2];
        e_scu = cnt[3];
    endtask

    // Emulate the units for one frame, then check the result and the handshake
    task automatic run_and_check(input string tag, input int e_cyc, input int e_cfu,
                                 input int e_vfu, input int e_scu, input int e_iter,
                                 input bit e_ok, input bit e_to,
                                 input logic [N_BITS-1:0] e_bits, input int hold,
                                 input bit fv_hold);
        int         t0;
        int         ph;
        int         cur;
        int         s;
        int         n [4];
        bit         got;
        bit         stable;
        logic [3:0] ends;
        n   = '{0, 0, 0, 0};
        ph  = -1;
        cur = -1;
        s   = 0;
        got = 1'b0;
        check({tag, ":ready_idle"}, bus.frame_ready, 1);
        bus.frame_valid = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge sys_clk);
            bus.frame_valid = 1'b0;
            if (bus.flag_init_start) begin n[0]++; cur = 0; ph++; s = cyc; end
            if (bus.flag_CFU_start)  begin n[1]++; cur = 1; ph++; s = cyc; end
            if (bus.flag_VFU_start)  begin n[2]++; cur = 2; ph++; s = cyc; end
            if (bus.flag_SCU_start)  begin n[3]++; cur = 3; ph++; s = cyc; end
            got             = bus.dec_valid;
            ends            = 4'b0000;
            bus.syndrome_ok = 1'($urandom);
            bus.bit_data_in = rand_word();
            bus.dec_ready   = 1'($urandom);
            if (got) begin
                bus.dec_ready = 1'b0;
            end else if (cur >= 0 && ph < NPH) begin
                for (int u = 0; u < 4; u++) if (u != cur && $urandom_range(0, 3) == 0) ends[u] = 1'b1;
                if (cyc == s + lat[ph]) begin
                    ends[cur] = 1'b1;
                    if (cur == 3) begin
                        bus.syndrome_ok = synd[(ph - 1) / 3];
                        bus.bit_data_in = word[(ph - 1) / 3];
                    end
                end
            end
            drive_ends(ends);
        end
        drive_ends(4'b0000);
        check({tag, ":latency"}, got ? cyc - t0 : -1, e_cyc);
        if (!got) begin
            clear_inputs();
            sys_rst_n = 1'b0;
            @(negedge sys_clk);
            sys_rst_n = 1'b1;
            last_bits = '0;
            @(negedge sys_clk);
            return;
        end
        check({tag, ":n_init"}, n[0], 1);
        check({tag, ":n_cfu"}, n[1], e_cfu);
        check({tag, ":n_vfu"}, n[2], e_vfu);
        check({tag, ":n_scu"}, n[3], e_scu);
        check({tag, ":iter"}, bus.dec_iter, e_iter);
        check({tag, ":ok_to"}, {bus.dec_ok, bus.dec_timeout}, {e_ok, e_to});
        check({tag, ":bits"}, bus.dec_bits, e_bits);
        check({tag, ":ready_busy"}, bus.frame_ready, 0);
        stable          = 1'b1;
        bus.frame_valid = fv_hold;
        for (int k = 0; k < hold; k++) begin
            @(negedge sys_clk);
            if (bus.dec_valid !== 1'b1 || bus.frame_ready !== 1'b0 || bus.dec_bits !== e_bits ||
                bus.dec_iter !== ITER_W'(e_iter) || bus.dec_ok !== e_ok ||
                bus.dec_timeout !== e_to || any_start() !== 1'b0) stable = 1'b0;
        end
        check({tag, ":hold_stable"}, stable, 1);
        bus.dec_ready = 1'b1;
        @(negedge sys_clk);
        bus.dec_ready = 1'b0;
        check({tag, ":released"}, {bus.frame_ready, bus.dec_valid}, 2'b10);
        last_bits = e_bits;
    endtask

    initial begin
        #5000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N_BITS-1:0] base;
        logic [N_BITS-1:0] e_bits;
        int                e_cyc, e_cfu, e_vfu, e_scu, e_iter;
        bit                e_ok, e_to;
        bit                quiet;
        int                r;

        // l, pass_it, hang_ph, e_cyc, e_cfu, e_vfu, e_scu, e_iter, e_ok, e_to, widx, hold
        vecs[0] = '{5,  0, -1, 25, 1, 1, 1, 1, 1, 0,  0, 2};
        vecs[1] = '{5, -1, -1, 61, 3, 3, 3, 3, 0, 0,  2, 0};
        vecs[2] = '{5, -1,  2, 29, 1, 1, 0, 0, 0, 1, -1, 1};
        vecs[3] = '{3,  1, -1, 29, 2, 2, 2, 2, 1, 0,  1, 3};
        vecs[4] = '{15, 0, -1, 65, 1, 1, 1, 1, 1, 0,  0, 0};
        vecs[5] = '{5, -1,  0, 17, 0, 0, 0, 0, 0, 1, -1, 2};
        vecs[6] = '{5, -1,  6, 53, 2, 2, 2, 1, 0, 1,  0, 1};
        vecs[7] = '{1,  2, -1, 21, 3, 3, 3, 3, 1, 0,  2, 0};

        clear_inputs();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        check_reset_vals("reset");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        for (int i = 0; i < 8; i++) begin
            base = (i == 0) ? N_BITS'(12'h1A5) : rand_word();
            set_plan(vecs[i].l, vecs[i].pass_it, vecs[i].hang_ph, base);
            e_bits = (vecs[i].widx < 0) ? last_bits : base + N_BITS'(vecs[i].widx);
            run_and_check($sformatf("vec%0d", i), vecs[i].e_cyc, vecs[i].e_cfu, vecs[i].e_vfu,
                          vecs[i].e_scu, vecs[i].e_iter, vecs[i].e_ok, vecs[i].e_to, e_bits,
                          vecs[i].hold, 1'b0);
        end

        // Backpressure with a waiting frame, then re-accept and abort in INIT
        set_plan(4, 0, -1, rand_word());
        run_and_check("hold10", 21, 1, 1, 1, 1, 1'b1, 1'b0, word[0], 10, 1'b1);
        @(negedge sys_clk);
        check("hold10:reaccept", {bus.flag_init_start, bus.frame_ready}, 2'b10);
        bus.frame_valid = 1'b0;
        bus.dec_abort   = 1'b1;
        @(negedge sys_clk);
        bus.dec_abort = 1'b0;
        check("abort_init:state", {bus.frame_ready, bus.dec_valid, bus.flag_CFU_start}, 3'b100);
        check("abort_init:bits", bus.dec_bits, last_bits);
        check("abort_init:flags", {bus.dec_ok, bus.dec_timeout, bus.dec_iter}, '0);

        // Stray end flags in CFU, then abort together with flag_CFU_end
        bus.frame_valid = 1'b1;
        @(negedge sys_clk);
        bus.frame_valid = 1'b0;
        check("abort_cfu:init_start", bus.flag_init_start, 1);
        drive_ends(4'b0001);
        @(negedge sys_clk);
        check("abort_cfu:cfu_start", bus.flag_CFU_start, 1);
        drive_ends(4'b1101);
        @(negedge sys_clk);
        check("abort_cfu:stray_ignored", {bus.flag_CFU_start, bus.flag_VFU_start,
                                          bus.flag_SCU_start, bus.dec_valid}, 4'b0000);
        drive_ends(4'b0010);
        bus.dec_abort = 1'b1;
        @(negedge sys_clk);
        drive_ends(4'b0000);
        bus.dec_abort = 1'b0;
        check("abort_cfu:idle", {bus.frame_ready, bus.dec_valid, bus.flag_VFU_start}, 3'b100);
        quiet = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (any_start() !== 1'b0 || bus.dec_valid !== 1'b0 || bus.frame_ready !== 1'b1)
                quiet = 1'b0;
        end
        check("abort_cfu:quiet", quiet, 1);
        check("abort_cfu:bits", bus.dec_bits, last_bits);

        // Asynchronous reset in the middle of VFU
        bus.frame_valid = 1'b1;
        @(negedge sys_clk);
        bus.frame_valid = 1'b0;
        drive_ends(4'b0001);
        @(negedge sys_clk);
        drive_ends(4'b0010);
        @(negedge sys_clk);
        drive_ends(4'b0000);
        check("rst_vfu:vfu_start", bus.flag_VFU_start, 1);
        @(negedge sys_clk);
        #3 sys_rst_n = 1'b0;
        #1 check_reset_vals("rst_vfu");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        last_bits = '0;
        @(negedge sys_clk);
        set_plan(2, 0, -1, rand_word());
        run_and_check("after_rst", 13, 1, 1, 1, 1, 1'b1, 1'b0, word[0], 1, 1'b0);

        // Randomized frames against the phase-walk model
        for (int f = 0; f < 40; f++) begin
            for (int p = 0; p < NPH; p++) lat[p] = $urandom_range(1, 6);
            for (int i = 0; i < MAX_ITER; i++) begin
                synd[i] = ($urandom_range(0, 2) == 0);
                word[i] = rand_word();
            end
            r = $urandom_range(0, 9);
            if (r == 0) lat[$urandom_range(0, NPH - 1)] = TIMEOUT - 1;
            if (r == 1) lat[$urandom_range(0, NPH - 1)] = TIMEOUT + $urandom_range(0, 4);
            model(e_cyc, e_cfu, e_vfu, e_scu, e_iter, e_ok, e_to, e_bits);
            run_and_check($sformatf("rnd%0d", f), e_cyc, e_cfu, e_vfu, e_scu, e_iter, e_ok, e_to,
                          e_bits, $urandom_range(0, 3), 1'($urandom));
            bus.frame_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
